mem_preloader: RTL and testbench

- Synthesizable boot preloader for N single-port SSRAMs (sram_32_1024_freepdk45 class).
- Fills each memory in turn from one valid/ready word stream, then releases core reset.
- After release, hands each SRAM port to its functional owner (ssram_wrap) through a transparent mux.
- Sits between the ssram_wrap instances, the SRAM macros and riscv_core's RSTn.

---
 rtl/preload_pkg.sv | 16 +
 rtl/preload_port_mux.sv | 35 +++
 rtl/mem_preloader.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_preloader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/preload_pkg.sv
// Shared types and constants for the boot-time SRAM preloader.
package preload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEXT,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } preload_state_t;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH      = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/preload_port_mux.sv
// Per-SRAM port selector: loader drive while preloading, functional owner once sel=1.
module preload_port_mux #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              sel,
  input  logic              f_csb,
  input  logic              f_web,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_din,
  input  logic              l_csb,
  input  logic              l_web,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_din,
  output logic              m_csb,
  output logic              m_web,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din
);

  always_comb begin
    if (sel) begin
      m_csb  = f_csb;
      m_web  = f_web;
      m_addr = f_addr;
      m_din  = f_din;
    end else begin
      m_csb  = l_csb;
      m_web  = l_web;
      m_addr = l_addr;
      m_din  = l_din;
    end
  end

endmodule

// File: rtl/mem_preloader.sv
// Boot preloader: fills N_MEM SRAMs from one word stream, then releases core reset.
// Optional readback checksum verification is enabled with `define PRELOAD_VERIFY_EN.
module mem_preloader
  import preload_pkg::*;
#(
  parameter int unsigned N_MEM  = 2,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CW    = (N_MEM > 1) ? $clog2(N_MEM) : 1
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      START,
  input  logic [N_MEM*(ADDR_W+1)-1:0] LEN,
  input  logic                      S_VALID,
  output logic                      S_READY,
  input  logic [DATA_W-1:0]         S_DATA,
  input  logic [N_MEM-1:0]          F_CSB,
  input  logic [N_MEM-1:0]          F_WEB,
  input  logic [N_MEM*ADDR_W-1:0]   F_ADDR,
  input  logic [N_MEM*DATA_W-1:0]   F_DIN,
  output logic [N_MEM-1:0]          M_CSB,
  output logic [N_MEM-1:0]          M_WEB,
  output logic [N_MEM*ADDR_W-1:0]   M_ADDR,
  output logic [N_MEM*DATA_W-1:0]   M_DIN,
  input  logic [N_MEM*DATA_W-1:0]   M_DOUT,
  output logic                      CORE_RSTn,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic [CW-1:0]             CHAN
);

  localparam int unsigned LW        = ADDR_W + 1;
  localparam int unsigned SW        = CW + 1;
  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;

  preload_state_t state, state_n;
  logic [CW-1:0]  chan;
  logic [SW-1:0]  scan;
  logic [LW-1:0]  cnt;
  logic [LW-1:0]  len_q   [N_MEM];
  logic [LW-1:0]  len_sat [N_MEM];
  logic           core_rstn;

  logic           found;
  logic [CW-1:0]  pick;
  logic           last_word;
  logic           verify_end;
  logic           verify_ok;

  logic              l_csb  [N_MEM];
  logic              l_web  [N_MEM];
  logic [ADDR_W-1:0] l_addr [N_MEM];
  logic [DATA_W-1:0] l_din  [N_MEM];

  always_comb begin
    for (int unsigned c = 0; c < N_MEM; c++) begin
      len_sat[c] = LEN[c*LW +: LW];
      if (len_sat[c] > LW'(MEM_DEPTH)) len_sat[c] = LW'(MEM_DEPTH);
    end
  end

  // scan holds the lowest channel still eligible; it may run one past the last channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned c = 0; c < N_MEM; c++) begin
      if (!found && SW'(c) >= scan && len_q[c] != '0) begin
        found = 1'b1;
        pick  = CW'(c);
      end
    end
  end

  assign last_word = (cnt == len_q[chan] - LW'(1));

`ifdef PRELOAD_VERIFY_EN
  logic [DATA_W-1:0] sum_w [N_MEM];
  logic [DATA_W-1:0] sum_r;
  logic              rd_pend;
  logic [DATA_W-1:0] dout_ch;

  always_comb begin
    dout_ch = '0;
    for (int unsigned c = 0; c < N_MEM; c++)
      if (chan == CW'(c)) dout_ch = M_DOUT[c*DATA_W +: DATA_W];
  end

  assign verify_end = (state == ST_VERIFY) && (cnt == len_q[chan]);
  assign verify_ok  = (sum_r + dout_ch) == sum_w[chan];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned c = 0; c < N_MEM; c++) sum_w[c] <= '0;
      sum_r   <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= (state == ST_VERIFY) && (cnt < len_q[chan]);
      if (state == ST_IDLE && START)
        for (int unsigned c = 0; c < N_MEM; c++) sum_w[c] <= '0;
      else if (state == ST_LOAD && S_VALID)
        sum_w[chan] <= sum_w[chan] + S_DATA;
      if (state == ST_LOAD) sum_r <= '0;
      else if (rd_pend)     sum_r <= sum_r + dout_ch;
    end
  end
`else
  logic unused_dout;
  assign unused_dout = ^M_DOUT;
  assign verify_end  = 1'b0;
  assign verify_ok   = 1'b1;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (START) state_n = ST_NEXT;
      ST_NEXT: state_n = found ? ST_LOAD : ST_DONE;
      ST_LOAD: begin
        if (S_VALID && last_word) begin
`ifdef PRELOAD_VERIFY_EN
          state_n = ST_VERIFY;
`else
          state_n = ST_NEXT;
`endif
        end
      end
      ST_VERIFY: if (verify_end) state_n = verify_ok ? ST_NEXT : ST_ERROR;
      default: state_n = state;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      chan      <= '0;
      scan      <= '0;
      cnt       <= '0;
      core_rstn <= 1'b0;
      for (int unsigned c = 0; c < N_MEM; c++) len_q[c] <= '0;
    end else begin
      state     <= state_n;
      core_rstn <= (state_n == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (START) begin
            for (int unsigned c = 0; c < N_MEM; c++) len_q[c] <= len_sat[c];
            scan <= '0;
            chan <= '0;
            cnt  <= '0;
          end
        end
        ST_NEXT: begin
          cnt <= '0;
          if (found) chan <= pick;
        end
        ST_LOAD: begin
          if (S_VALID) begin
            if (last_word) begin
              cnt  <= '0;
              scan <= SW'(chan) + SW'(1);
            end else begin
              cnt <= cnt + LW'(1);
            end
          end
        end
        ST_VERIFY: begin
          if (verify_end) begin
            cnt  <= '0;
            scan <= SW'(chan) + SW'(1);
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < N_MEM; c++) begin
      l_csb[c]  = 1'b1;
      l_web[c]  = 1'b1;
      l_addr[c] = '0;
      l_din[c]  = '0;
      if (chan == CW'(c)) begin
        if (state == ST_LOAD && S_VALID) begin
          l_csb[c]  = 1'b0;
          l_web[c]  = 1'b0;
          l_addr[c] = cnt[ADDR_W-1:0];
          l_din[c]  = S_DATA;
        end else if (state == ST_VERIFY && cnt < len_q[c]) begin
          l_csb[c]  = 1'b0;
          l_addr[c] = cnt[ADDR_W-1:0];
        end
      end
    end
  end

  for (genvar g = 0; g < N_MEM; g++) begin : g_mux
    preload_port_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_mux (
      .sel    (state == ST_DONE),
      .f_csb  (F_CSB[g]),
      .f_web  (F_WEB[g]),
      .f_addr (F_ADDR[g*ADDR_W +: ADDR_W]),
      .f_din  (F_DIN[g*DATA_W +: DATA_W]),
      .l_csb  (l_csb[g]),
      .l_web  (l_web[g]),
      .l_addr (l_addr[g]),
      .l_din  (l_din[g]),
      .m_csb  (M_CSB[g]),
      .m_web  (M_WEB[g]),
      .m_addr (M_ADDR[g*ADDR_W +: ADDR_W]),
      .m_din  (M_DIN[g*DATA_W +: DATA_W])
    );
  end

  assign S_READY   = (state == ST_LOAD);
  assign CORE_RSTn = core_rstn;
  assign BUSY      = (state == ST_NEXT) || (state == ST_LOAD) || (state == ST_VERIFY);
  assign DONE      = (state == ST_DONE);
  assign ERR       = (state == ST_ERROR);
  assign CHAN      = chan;

endmodule

// File: tb/tb_mem_preloader.sv
// Scoreboard bench for mem_preloader: stimulus queues expected SRAM writes, a monitor pops them.
module tb_mem_preloader;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NM = 2;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              START = 1'b0;
  logic [NM*(AW+1)-1:0] LEN = '0;
  logic              S_VALID = 1'b0;
  logic              S_READY;
  logic [DW-1:0]     S_DATA = '0;
  logic [NM-1:0]     F_CSB = '1;
  logic [NM-1:0]     F_WEB = '1;
  logic [NM*AW-1:0]  F_ADDR = '0;
  logic [NM*DW-1:0]  F_DIN = '0;
  logic [NM-1:0]     M_CSB;
  logic [NM-1:0]     M_WEB;
  logic [NM*AW-1:0]  M_ADDR;
  logic [NM*DW-1:0]  M_DIN;
  logic [NM*DW-1:0]  M_DOUT;
  logic              CORE_RSTn;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic              CHAN;

  mem_preloader #(.N_MEM(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .LEN(LEN),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .F_CSB(F_CSB), .F_WEB(F_WEB), .F_ADDR(F_ADDR), .F_DIN(F_DIN),
    .M_CSB(M_CSB), .M_WEB(M_WEB), .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_DOUT(M_DOUT),
    .CORE_RSTn(CORE_RSTn), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CHAN(CHAN)
  );

  always #5 CLK = ~CLK;

  // SRAM models with optional read corruption at dmem address 4
  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] dout0 = '0;
  logic [DW-1:0] dout1 = '0;
  bit            corrupt = 1'b0;
  assign M_DOUT = {dout1, dout0};

  always @(posedge CLK) begin
    if (!M_CSB[0]) begin
      if (!M_WEB[0]) mem0[M_ADDR[AW-1:0]] <= M_DIN[DW-1:0];
      else           dout0 <= mem0[M_ADDR[AW-1:0]];
    end
    if (!M_CSB[1]) begin
      if (!M_WEB[1]) mem1[M_ADDR[2*AW-1:AW]] <= M_DIN[2*DW-1:DW];
      else           dout1 <= (corrupt && M_ADDR[2*AW-1:AW] == 10'd4) ? '0 : mem1[M_ADDR[2*AW-1:AW]];
    end
  end

  typedef struct { int chan; int addr; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  bit csb0_seen = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  always @(negedge CLK) begin
    if (RSTn && !DONE) begin
      if (!M_CSB[0]) csb0_seen = 1'b1;
      for (int c = 0; c < NM; c++) begin
        if (!M_CSB[c] && !M_WEB[c]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(c), 64'hFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_chan", 64'(c), 64'(e.chan));
            check("wr_addr", 64'(M_ADDR[c*AW +: AW]), 64'(e.addr));
            check("wr_data", 64'(M_DIN[c*DW +: DW]), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic check_reset();
    check("rst_core_rstn", 64'(CORE_RSTn), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_s_ready", 64'(S_READY), 64'd0);
    check("rst_chan", 64'(CHAN), 64'd0);
    check("rst_m_csb", 64'(M_CSB), 64'd3);
    check("rst_m_web", 64'(M_WEB), 64'd3);
    check("rst_m_addr", 64'(M_ADDR), 64'd0);
    check("rst_m_din", 64'(M_DIN), 64'd0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0; START = 1'b0; S_VALID = 1'b0;
    F_CSB = '1; F_WEB = '1; F_ADDR = '0; F_DIN = '0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 check_reset();
    @(posedge CLK) #1 RSTn = 1'b1;
  endtask

  task automatic start(input int len0, input int len1);
    @(posedge CLK) #1;
    START = 1'b1;
    LEN = {11'(len1), 11'(len0)};
    @(posedge CLK) #1 START = 1'b0;
  endtask

  // Words are queued on first presentation; len0 selects imem/dmem split.
  task automatic stream(input int n, input int len0, input logic [DW-1:0] base, input bit toggle);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      bit acc;
      int guard;
      @(posedge CLK) #1;
      S_VALID = 1'b1;
      S_DATA = base + DW'(i);
      e.chan = (i < len0) ? 0 : 1;
      e.addr = (i < len0) ? i : i - len0;
      e.data = base + DW'(i);
      exp_q.push_back(e);
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge CLK);
        if (S_READY) acc = 1'b1;
        else begin
          guard++;
          if (guard > 2000) begin
            check("handshake_timeout", 64'd0, 64'd1);
            acc = 1'b1;
          end else @(posedge CLK) #1;
        end
      end
      if (toggle && i != n - 1) begin
        @(posedge CLK) #1 S_VALID = 1'b0;
      end
    end
    @(posedge CLK) #1 S_VALID = 1'b0;
  endtask

  task automatic wait_rise(output int k);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!CORE_RSTn && k < 3000);
  endtask

  task automatic readback(input int len0, input int len1, input logic [DW-1:0] base);
    for (int i = 0; i < len0; i++) check("imem_rb", 64'(mem0[i]), 64'(base + DW'(i)));
    for (int j = 0; j < len1; j++) check("dmem_rb", 64'(mem1[j]), 64'(base + DW'(len0 + j)));
  endtask

  task automatic full_load(input int len0, input int len1, input logic [DW-1:0] base, input bit toggle);
    int k;
    int exp_k;
    start(len0, len1);
    stream(len0 + len1, len0, base, toggle);
    wait_rise(k);
    exp_k = 2;
`ifdef PRELOAD_VERIFY_EN
    exp_k = exp_k + ((len1 != 0) ? len1 : len0) + 1;
`endif
    check("core_rstn_delay", 64'(k), 64'(exp_k));
    #1;
    check("done", 64'(DONE), 64'd1);
    check("busy_done", 64'(BUSY), 64'd0);
    check("err_done", 64'(ERR), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // T0: reset values, F_* ignored before DONE
    do_reset();
    F_CSB = 2'b01; F_WEB = 2'b01; F_ADDR = {10'd5, 10'd0}; F_DIN = {32'hDEADBEEF, 32'h0};
    #1;
    check("pre_done_f_csb", 64'(M_CSB), 64'd3);
    check("pre_done_f_addr", 64'(M_ADDR), 64'd0);
    check("pre_done_f_din", 64'(M_DIN), 64'd0);
    F_CSB = '1; F_WEB = '1; F_ADDR = '0; F_DIN = '0;

    // T1: imem 79 words, dmem 12 words, valid held high
    full_load(79, 12, 32'h1000, 1'b0);
    readback(79, 12, 32'h1000);
    check("imem_last", 64'(mem0[78]), 64'h104E);
    check("dmem_first", 64'(mem1[0]), 64'h104F);
    check("dmem_last", 64'(mem1[11]), 64'h105A);
    @(posedge CLK) #1 START = 1'b1;
    @(posedge CLK) #1 START = 1'b0;
    #1;
    check("start_ignored_done", 64'(DONE), 64'd1);
    check("start_ignored_busy", 64'(BUSY), 64'd0);

    // T5: functional passthrough in DONE
    F_CSB = 2'b01; F_WEB = 2'b01; F_ADDR = {10'd5, 10'd0}; F_DIN = {32'hDEADBEEF, 32'h0};
    #1;
    check("pt_csb", 64'(M_CSB), 64'd1);
    check("pt_web", 64'(M_WEB), 64'd1);
    check("pt_addr1", 64'(M_ADDR[2*AW-1:AW]), 64'd5);
    check("pt_din1", 64'(M_DIN[2*DW-1:DW]), 64'hDEADBEEF);
    @(posedge CLK) #1;
    F_CSB = '1; F_WEB = '1; F_ADDR = '0; F_DIN = '0;
    check("pt_written", 64'(mem1[5]), 64'hDEADBEEF);

    // T2: same split, valid toggling every cycle
    do_reset();
    full_load(79, 12, 32'h3000, 1'b1);
    readback(79, 12, 32'h3000);

    // T3: imem empty, dmem 3 words
    do_reset();
    csb0_seen = 1'b0;
    full_load(0, 3, 32'h7000, 1'b0);
    check("csb0_idle", 64'(csb0_seen), 64'd0);
    readback(0, 3, 32'h7000);

    // T4: reset after 40 words, then reload from address 0
    do_reset();
    start(79, 12);
    stream(40, 79, 32'h4000, 1'b0);
    check("mid_busy", 64'(BUSY), 64'd1);
    @(posedge CLK) #1;
    S_VALID = 1'b1; S_DATA = 32'hBAD0BAD0;
    #1 check("mid_write_csb0", 64'(M_CSB[0]), 64'd0);
    #1 RSTn = 1'b0;
    #1 check_reset();
    check("mid_queue_empty", 64'(exp_q.size()), 64'd0);
    S_VALID = 1'b0;
    @(posedge CLK) #1 RSTn = 1'b1;
    full_load(79, 12, 32'h5000, 1'b0);
    readback(79, 12, 32'h5000);

`ifdef PRELOAD_VERIFY_EN
    // T6: corrupted readback traps in ERROR; clean readback completes
    do_reset();
    corrupt = 1'b1;
    start(5, 8);
    stream(13, 5, 32'h6000, 1'b0);
    repeat (40) @(negedge CLK);
    check("vf_err", 64'(ERR), 64'd1);
    check("vf_done", 64'(DONE), 64'd0);
    check("vf_core_rstn", 64'(CORE_RSTn), 64'd0);
    check("vf_busy", 64'(BUSY), 64'd0);
    check("vf_csb_idle", 64'(M_CSB), 64'd3);
    corrupt = 1'b0;
    do_reset();
    full_load(5, 8, 32'h6000, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
